uart_word_bridge: RTL and testbench

UART_WORD_BRIDGE -- requirements
Module: uart_word_bridge

---
 rtl/uart_bridge_pkg.sv | 31 +++
 rtl/word_serializer.sv | 76 +++++++
 rtl/uart_word_bridge.sv | 106 ++++++++++
 tb/tb_uart_word_bridge.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART word bridge: default widths, the derived
// bytes-per-word constant, the rx/tx state encodings and a small index-width
// helper used by both halves.
package uart_bridge_pkg;

  localparam int unsigned DEF_BITS_DATA  = 32'd8;
  localparam int unsigned DEF_WORD_BITS  = 32'd32;
  localparam int unsigned BYTES_PER_WORD = DEF_WORD_BITS / DEF_BITS_DATA;

  typedef enum logic {
    RX_COLLECT = 1'b0,
    RX_HOLD    = 1'b1
  } rx_state_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  // Width of a byte-lane index for a word of n bytes; never narrower than 1 bit.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    if (n > 32'd1) begin
      w = $clog2(n);
    end else begin
      w = 32'd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Transmit half of the bridge: captures a word on a valid/ready handshake and
// pushes it into the UART tx FIFO one byte per cycle, least significant byte
// first, stalling without loss while the FIFO reports full.
module word_serializer
  import uart_bridge_pkg::*;
#(
  parameter int unsigned BITS_DATA = DEF_BITS_DATA,
  parameter int unsigned WORD_BITS = DEF_WORD_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tx_full,
  output logic                 o_write_uart,
  output logic [BITS_DATA-1:0] o_tx_data,
  input  logic [WORD_BITS-1:0] i_word_in,
  input  logic                 i_word_valid,
  output logic                 o_word_ready
);

  localparam int unsigned N  = WORD_BITS / BITS_DATA;
  localparam int unsigned IW = idx_width(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 32'd1);

  tx_state_e               state_q;
  logic [IW-1:0]           idx_q;
  logic [WORD_BITS-1:0]    word_q;
  logic                    push_s;

  // Push strobe: only while sending, FIFO not full and not in reset.
  always_comb begin
    push_s = 1'b0;
    if ((state_q == TX_SEND) && !i_tx_full && !i_reset) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // Tx FSM: capture on handshake, step the byte index on every push.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= TX_IDLE;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (i_word_valid) begin
            word_q  <= i_word_in;
            idx_q   <= '0;
            state_q <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (push_s) begin
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              state_q <= TX_IDLE;
            end else begin
              idx_q <= idx_q + {{(IW-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          idx_q   <= '0;
          state_q <= TX_IDLE;
        end
      endcase
    end
  end

  assign o_write_uart = push_s;
  assign o_tx_data    = word_q[idx_q*BITS_DATA +: BITS_DATA];
  assign o_word_ready = (state_q == TX_IDLE);

endmodule

// File: rtl/uart_word_bridge.sv
// Bridges a byte-wide UART FIFO pair to a word-wide valid/ready interface.
// The rx half (inline) assembles N bytes little-endian into a held word; the
// tx half (word_serializer) splits a word into N byte pushes. The two halves
// share only the clock and reset.
module uart_word_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned BITS_DATA = DEF_BITS_DATA,
  parameter int unsigned WORD_BITS = DEF_WORD_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx_empty,
  input  logic [BITS_DATA-1:0] i_rx_data,
  output logic                 o_read_uart,
  input  logic                 i_tx_full,
  output logic                 o_write_uart,
  output logic [BITS_DATA-1:0] o_tx_data,
  input  logic [WORD_BITS-1:0] i_word_in,
  input  logic                 i_word_valid,
  output logic                 o_word_ready,
  output logic [WORD_BITS-1:0] o_word_out,
  output logic                 o_word_valid,
  input  logic                 i_word_ready,
  input  logic                 i_rx_flush
);

  localparam int unsigned N  = WORD_BITS / BITS_DATA;
  localparam int unsigned CW = idx_width(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 32'd1);

  rx_state_e               rx_state_q;
  logic [CW-1:0]           cnt_q;
  logic [WORD_BITS-1:0]    word_q;
  logic                    valid_q;
  logic                    pop_s;

  // Pop strobe: collecting, a byte is available, no flush and not in reset.
  always_comb begin
    pop_s = 1'b0;
    if ((rx_state_q == RX_COLLECT) && !i_rx_empty && !i_rx_flush && !i_reset) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Rx FSM: latch popped bytes into their lane, hold the word until taken.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_state_q <= RX_COLLECT;
      cnt_q      <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
    end else if (i_rx_flush) begin
      rx_state_q <= RX_COLLECT;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      case (rx_state_q)
        RX_COLLECT: begin
          if (pop_s) begin
            word_q[cnt_q*BITS_DATA +: BITS_DATA] <= i_rx_data;
            if (cnt_q == LAST_CNT) begin
              cnt_q      <= '0;
              rx_state_q <= RX_HOLD;
              valid_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
          end
        end
        RX_HOLD: begin
          if (i_word_ready) begin
            rx_state_q <= RX_COLLECT;
            valid_q    <= 1'b0;
          end
        end
        default: begin
          rx_state_q <= RX_COLLECT;
          cnt_q      <= '0;
          valid_q    <= 1'b0;
        end
      endcase
    end
  end

  assign o_read_uart  = pop_s;
  assign o_word_out   = word_q;
  assign o_word_valid = valid_q;

  word_serializer #(
    .BITS_DATA (BITS_DATA),
    .WORD_BITS (WORD_BITS)
  ) u_word_serializer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_tx_full    (i_tx_full),
    .o_write_uart (o_write_uart),
    .o_tx_data    (o_tx_data),
    .i_word_in    (i_word_in),
    .i_word_valid (i_word_valid),
    .o_word_ready (o_word_ready)
  );

endmodule

// File: tb/tb_uart_word_bridge.sv
// Directed bench for uart_word_bridge: a queue models the rx FIFO, a log
// records every tx push with its cycle number, and all expectations are
// hand-computed constants.
module tb_uart_word_bridge;

  logic        clk;
  logic        i_reset;
  logic        i_rx_empty;
  logic [7:0]  i_rx_data;
  logic        o_read_uart;
  logic        i_tx_full;
  logic        o_write_uart;
  logic [7:0]  o_tx_data;
  logic [31:0] i_word_in;
  logic        i_word_valid;
  logic        o_word_ready;
  logic [31:0] o_word_out;
  logic        o_word_valid;
  logic        i_word_ready;
  logic        i_rx_flush;

  logic [7:0]  rxq[$];
  logic [7:0]  txlog[$];
  int          txcyc[$];
  int          cyc;
  int          pops;
  int          n_checks;
  int          n_pass;
  int          h;
  logic        s_read;
  logic        s_write;
  logic [7:0]  s_txd;
  logic        s_ready;

  uart_word_bridge #(.BITS_DATA(8), .WORD_BITS(32)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_rx_empty   (i_rx_empty),
    .i_rx_data    (i_rx_data),
    .o_read_uart  (o_read_uart),
    .i_tx_full    (i_tx_full),
    .o_write_uart (o_write_uart),
    .o_tx_data    (o_tx_data),
    .i_word_in    (i_word_in),
    .i_word_valid (i_word_valid),
    .o_word_ready (o_word_ready),
    .o_word_out   (o_word_out),
    .o_word_valid (o_word_valid),
    .i_word_ready (i_word_ready),
    .i_rx_flush   (i_rx_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] tx_byte(input int i);
    if (txlog.size() > i) return {24'h0, txlog[i]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] tx_cycle(input int i);
    if (txcyc.size() > i) return txcyc[i];
    return 32'hFFFF_FFFF;
  endfunction

  // One clock cycle: present the rx FIFO head, sample strobes mid-cycle,
  // then apply FIFO pop / tx log after the edge. Returns at posedge+1.
  task automatic tick();
    @(negedge clk);
    i_rx_empty = (rxq.size() == 0);
    if (rxq.size() != 0) i_rx_data = rxq[0];
    else i_rx_data = 8'h00;
    #1;
    s_read  = o_read_uart;
    s_write = o_write_uart;
    s_txd   = o_tx_data;
    s_ready = o_word_ready;
    if (s_write) begin
      txlog.push_back(s_txd);
      txcyc.push_back(cyc);
    end
    @(posedge clk);
    if (s_read && (rxq.size() != 0)) begin
      void'(rxq.pop_front());
      pops++;
    end
    cyc++;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic consume_rx();
    i_word_ready = 1'b1;
    tick();
    i_word_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; pops = 0;
    i_reset = 1'b1; i_rx_empty = 1'b1; i_rx_data = 8'h00;
    i_tx_full = 1'b0; i_word_in = 32'h1111_2222; i_word_valid = 1'b1;
    i_word_ready = 1'b0; i_rx_flush = 1'b0;

    // Reset state, with rx data available and a word offered.
    rxq.push_back(8'hAA);
    tick();
    check_eq("rst_read", {31'h0, s_read}, 32'h0);
    check_eq("rst_write", {31'h0, s_write}, 32'h0);
    check_eq("rst_ready", {31'h0, s_ready}, 32'h1);
    check_eq("rst_valid", {31'h0, o_word_valid}, 32'h0);
    check_eq("rst_wout", o_word_out, 32'h0);
    check_eq("rst_txd", {24'h0, o_tx_data}, 32'h0);
    i_word_valid = 1'b0;
    rxq.delete();
    pops = 0;
    i_reset = 1'b0;
    tick();

    // Four bytes -> little-endian word one cycle after the last pop.
    rxq.push_back(8'h78); rxq.push_back(8'h56); rxq.push_back(8'h34); rxq.push_back(8'h12);
    ticks(3);
    check_eq("rx_valid_early", {31'h0, o_word_valid}, 32'h0);
    tick();
    check_eq("rx_pops4", pops, 32'd4);
    check_eq("rx_valid", {31'h0, o_word_valid}, 32'h1);
    check_eq("rx_word", o_word_out, 32'h1234_5678);

    // Backpressure: held word, no pops, then resume after release.
    rxq.push_back(8'h11); rxq.push_back(8'h22); rxq.push_back(8'h33);
    ticks(10);
    check_eq("hold_pops", pops, 32'd4);
    check_eq("hold_valid", {31'h0, o_word_valid}, 32'h1);
    check_eq("hold_word", o_word_out, 32'h1234_5678);
    i_word_ready = 1'b1;
    tick();
    check_eq("rel_read", {31'h0, s_read}, 32'h0);
    check_eq("rel_valid", {31'h0, o_word_valid}, 32'h0);
    i_word_ready = 1'b0;
    tick();
    check_eq("resume_pop", pops, 32'd5);
    rxq.push_back(8'h44);
    ticks(3);
    check_eq("rx2_word", o_word_out, 32'h4433_2211);
    check_eq("rx2_valid", {31'h0, o_word_valid}, 32'h1);
    consume_rx();

    // Flush after two bytes discards them.
    rxq.push_back(8'hAA); rxq.push_back(8'hBB);
    ticks(2);
    rxq.push_back(8'h01); rxq.push_back(8'h02); rxq.push_back(8'h03); rxq.push_back(8'h04);
    i_rx_flush = 1'b1;
    tick();
    check_eq("flush_read", {31'h0, s_read}, 32'h0);
    i_rx_flush = 1'b0;
    ticks(3);
    check_eq("flush_valid_early", {31'h0, o_word_valid}, 32'h0);
    tick();
    check_eq("flush_valid", {31'h0, o_word_valid}, 32'h1);
    check_eq("flush_word", o_word_out, 32'h0403_0201);
    check_eq("flush_pops", pops, 32'd14);
    consume_rx();

    // Tx with no backpressure.
    txlog.delete(); txcyc.delete();
    i_word_in = 32'hDEAD_BEEF; i_word_valid = 1'b1;
    tick();
    h = cyc - 1;
    i_word_valid = 1'b0;
    check_eq("tx_hs_ready", {31'h0, s_ready}, 32'h1);
    ticks(3);
    check_eq("tx_busy", {31'h0, o_word_ready}, 32'h0);
    tick();
    check_eq("tx_ready_back", {31'h0, o_word_ready}, 32'h1);
    check_eq("tx_cnt", txlog.size(), 32'd4);
    check_eq("tx_b0", tx_byte(0), 32'hEF);
    check_eq("tx_b1", tx_byte(1), 32'hBE);
    check_eq("tx_b2", tx_byte(2), 32'hAD);
    check_eq("tx_b3", tx_byte(3), 32'hDE);
    check_eq("tx_c0", tx_cycle(0), h + 1);
    check_eq("tx_c3", tx_cycle(3), h + 4);

    // Tx with a 3-cycle full stall after the second push.
    txlog.delete(); txcyc.delete();
    i_word_valid = 1'b1;
    tick();
    i_word_valid = 1'b0;
    ticks(2);
    i_tx_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("stall_write", {31'h0, s_write}, 32'h0);
    end
    i_tx_full = 1'b0;
    ticks(2);
    check_eq("stall_cnt", txlog.size(), 32'd4);
    check_eq("stall_b0", tx_byte(0), 32'hEF);
    check_eq("stall_b1", tx_byte(1), 32'hBE);
    check_eq("stall_b2", tx_byte(2), 32'hAD);
    check_eq("stall_b3", tx_byte(3), 32'hDE);
    check_eq("stall_gap", tx_cycle(2) - tx_cycle(1), 32'd4);
    check_eq("stall_ready", {31'h0, o_word_ready}, 32'h1);

    // Simultaneous rx and tx activity.
    txlog.delete(); txcyc.delete();
    rxq.push_back(8'h9A); rxq.push_back(8'hBC); rxq.push_back(8'hDE); rxq.push_back(8'hF0);
    i_word_in = 32'h55AA_33CC; i_word_valid = 1'b1;
    tick();
    i_word_valid = 1'b0;
    ticks(4);
    check_eq("sim_rx_word", o_word_out, 32'hF0DE_BC9A);
    check_eq("sim_rx_valid", {31'h0, o_word_valid}, 32'h1);
    check_eq("sim_tx_cnt", txlog.size(), 32'd4);
    check_eq("sim_tx_b0", tx_byte(0), 32'hCC);
    check_eq("sim_tx_b3", tx_byte(3), 32'h55);
    check_eq("sim_ready", {31'h0, o_word_ready}, 32'h1);
    consume_rx();

    // Reset in the middle of a transmission.
    txlog.delete(); txcyc.delete();
    i_word_in = 32'hDEAD_BEEF; i_word_valid = 1'b1;
    tick();
    i_word_valid = 1'b0;
    ticks(2);
    check_eq("mid_cnt", txlog.size(), 32'd2);
    i_reset = 1'b1;
    #1;
    check_eq("mid_rst_write", {31'h0, o_write_uart}, 32'h0);
    check_eq("mid_rst_ready", {31'h0, o_word_ready}, 32'h1);
    check_eq("mid_rst_valid", {31'h0, o_word_valid}, 32'h0);
    tick();
    check_eq("mid_rst_nopush", txlog.size(), 32'd2);
    i_reset = 1'b0;
    txlog.delete(); txcyc.delete();
    i_word_in = 32'h0A0B_0C0D; i_word_valid = 1'b1;
    tick();
    i_word_valid = 1'b0;
    ticks(4);
    check_eq("post_cnt", txlog.size(), 32'd4);
    check_eq("post_b0", tx_byte(0), 32'h0D);
    check_eq("post_b1", tx_byte(1), 32'h0C);
    check_eq("post_b2", tx_byte(2), 32'h0B);
    check_eq("post_b3", tx_byte(3), 32'h0A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
